tcb_lib_arbiter: RTL and testbench

Shares one TCB subordinate (typically the memory model or an SRAM controller) between `MPN` TCB managers. Selects one requesting manager per transfer, by fixed priority or round-robin, and holds the grant while the subordinate stalls. Tracks ownership of in-flight transfers through the `DLY`-stage response pipeline so each response returns to the manager that issued the request. Sits between CPU instruction/data ports or DMA engines and a single shared memory port.

---
 rtl/tcb_lib_arbiter_pkg.sv | 17 +
 rtl/tcb_lib_arbiter_if.sv | 13 +
 rtl/tcb_lib_arbiter_grant.sv | 23 ++
 rtl/tcb_lib_arbiter.sv | 77 +++++++
 tb/tb_tcb_lib_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/tcb_lib_arbiter_pkg.sv
// tcb_lib_arbiter_pkg: TCB payload types, arbitration mode and FSM states
package tcb_lib_arbiter_pkg;
    typedef enum logic {TCB_ARB_FIX, TCB_ARB_RR} tcb_arb_t;
    typedef enum logic {IDLE, HOLD} arb_state_t;
    typedef struct packed {
        logic        wen;
        logic [31:0] adr;
        logic [31:0] wdt;
    } tcb_req_t;
    typedef struct packed {
        logic [31:0] rdt;
        logic        sts;
    } tcb_rsp_t;
    function automatic int wrap_idx(int base, int off, int n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/tcb_lib_arbiter_if.sv
// tcb_lib_arbiter_if: bundle of N TCB ports sharing one PHY
interface tcb_lib_arbiter_if
    import tcb_lib_arbiter_pkg::*;
#(
    parameter int N = 1
);
    logic [N-1:0] vld;
    logic [N-1:0] rdy;
    tcb_req_t     req [N];
    tcb_rsp_t     rsp [N];
    modport man (output vld, req, input rdy, rsp);
    modport sub (input vld, req, output rdy, rsp);
endinterface

// File: rtl/tcb_lib_arbiter_grant.sv
// tcb_lib_arbiter_grant: combinational fixed-priority / round-robin winner select
module tcb_lib_arbiter_grant
    import tcb_lib_arbiter_pkg::*;
#(
    parameter int MPN = 2,
    parameter int IW  = $clog2(MPN)
) (
    input  tcb_arb_t       arb,
    input  logic [MPN-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [MPN-1:0] gnt,
    output logic [IW-1:0]  idx
);
    // scanned from the far end so the closest requester to ptr is written last
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = MPN - 1; i >= 0; i--)
            if (req[IW'(wrap_idx(arb == TCB_ARB_RR ? int'(ptr) : 0, i, MPN))])
                idx = IW'(wrap_idx(arb == TCB_ARB_RR ? int'(ptr) : 0, i, MPN));
        gnt[idx] = |req;
    end
endmodule

// File: rtl/tcb_lib_arbiter.sv
// tcb_lib_arbiter: shares one TCB subordinate among MPN managers with response routing
module tcb_lib_arbiter
    import tcb_lib_arbiter_pkg::*;
#(
    parameter int       MPN = 2,
    parameter tcb_arb_t ARB = TCB_ARB_RR,
    parameter int       DLY = 1
) (
    input  logic           clk,
    input  logic           rst,
    tcb_lib_arbiter_if.sub man,
    tcb_lib_arbiter_if.man sub,
    output logic [MPN-1:0] gnt
);
    localparam int IW = $clog2(MPN);
    arb_state_t     state, state_nxt;
    logic [IW-1:0]  ptr, own, win, owner, ri;
    logic [MPN-1:0] win_oh;
    logic           trn, rv;
    tcb_lib_arbiter_grant #(.MPN(MPN), .IW(IW)) u_grant (
        .arb (ARB),
        .req (man.vld),
        .ptr (ptr),
        .gnt (win_oh),
        .idx (win)
    );
    assign owner      = (state == HOLD) ? own : win;
    assign sub.vld[0] = man.vld[owner];
    assign sub.req[0] = man.req[owner];
    assign trn        = man.vld[owner] & sub.rdy[0];
    always_comb state_nxt = (state == HOLD) ? (trn ? IDLE : HOLD) : ((man.vld[owner] & ~sub.rdy[0]) ? HOLD : IDLE);
    always_comb gnt = (state == HOLD) ? MPN'(1) << own : win_oh;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            own   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == HOLD) own <= win;
            if (trn && ARB == TCB_ARB_RR) ptr <= (owner == IW'(MPN - 1)) ? '0 : owner + IW'(1);
        end
    end
    // only the owner index travels alongside the subordinate's own response latency
    generate
        if (DLY == 0) begin : g_nopl
            assign rv = trn;
            assign ri = owner;
        end else begin : g_opl
            logic [DLY-1:0] ov;
            logic [IW-1:0]  oi [DLY];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ov <= '0;
                    for (int d = 0; d < DLY; d++) oi[d] <= '0;
                end else begin
                    ov[0] <= trn;
                    oi[0] <= owner;
                    for (int d = 1; d < DLY; d++) begin
                        ov[d] <= ov[d-1];
                        oi[d] <= oi[d-1];
                    end
                end
            end
            assign rv = ov[DLY-1];
            assign ri = oi[DLY-1];
        end
    endgenerate
    always_comb begin
        man.rdy = '0;
        for (int i = 0; i < MPN; i++) begin
            man.rdy[i] = man.vld[i] & (owner == IW'(i)) & sub.rdy[0];
            man.rsp[i] = (rv && ri == IW'(i)) ? sub.rsp[0] : '0;
        end
    end
    hold_stable: assert property (@(posedge clk) disable iff (!rst) state == HOLD |-> man.vld[own]);
endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// tb_tcb_lib_arbiter: directed checks of round-robin (MPN=4, DLY=2) and fixed-priority (MPN=3, DLY=1) arbiters
module tb_tcb_lib_arbiter;
    import tcb_lib_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy_r = 1'b1;
    int total = 0;
    int bad = 0;
    logic [3:0] gnt_r;
    logic [2:0] gnt_f;
    always #5 clk = ~clk;
    tcb_lib_arbiter_if #(.N(4)) mr ();
    tcb_lib_arbiter_if #(.N(1)) sr ();
    tcb_lib_arbiter_if #(.N(3)) mf ();
    tcb_lib_arbiter_if #(.N(1)) sf ();
    tcb_lib_arbiter #(.MPN(4), .ARB(TCB_ARB_RR), .DLY(2)) dut_rr (
        .clk (clk), .rst (rst), .man (mr), .sub (sr), .gnt (gnt_r)
    );
    tcb_lib_arbiter #(.MPN(3), .ARB(TCB_ARB_FIX), .DLY(1)) dut_fix (
        .clk (clk), .rst (rst), .man (mf), .sub (sf), .gnt (gnt_f)
    );
    // subordinate models: read data is the address byte repeated unless written;
    // idle cycles return junk so misrouted responses are visible
    logic [31:0] mem_r [256];
    logic [7:0]  a_r, a_f;
    tcb_rsp_t    q1_r, q2_r, q1_f;
    assign a_r = sr.req[0].adr[9:2];
    assign a_f = sf.req[0].adr[9:2];
    assign sr.rdy = rdy_r;
    assign sr.rsp[0] = q2_r;
    assign sf.rdy = 1'b1;
    assign sf.rsp[0] = q1_f;
    always_ff @(posedge clk) begin
        if (!rst) for (int i = 0; i < 256; i++) mem_r[i] <= '0;
        else if (sr.vld[0] && sr.rdy[0] && sr.req[0].wen) mem_r[a_r] <= sr.req[0].wdt ^ {4{a_r}};
        if (sr.vld[0] && sr.rdy[0]) q1_r <= sr.req[0].wen ? '0 : {mem_r[a_r] ^ {4{a_r}}, 1'b0};
        else q1_r <= {32'hbad0bad0, 1'b1};
        q2_r <= q1_r;
        q1_f <= (sf.vld[0] && sf.rdy[0]) ? {{4{a_f}}, 1'b0} : {32'hbad0bad0, 1'b1};
    end
    task automatic chk(string tag, logic [32:0] got, logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic setr(int i, logic wen, logic [31:0] adr, logic [31:0] wdt);
        mr.req[i] = {wen, adr, wdt};
    endtask
    function automatic logic [32:0] rd(logic [7:0] a);
        return {{4{a}}, 1'b0};
    endfunction
    initial begin
        mr.vld = '0;
        mf.vld = '0;
        for (int i = 0; i < 4; i++) setr(i, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) mf.req[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt_r", gnt_r, '0);
        chk("rst_gnt_f", gnt_f, '0);
        chk("rst_sub_vld", sr.vld[0], '0);
        chk("rst_rdy", mr.rdy, '0);
        chk("rst_rsp", mr.rsp[0], '0);
        rst = 1'b1;
        // round-robin rotation with all four requesting
        for (int i = 0; i < 4; i++) setr(i, 1'b0, 32'h40 + 4 * i, '0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            mr.vld = (c < 6) ? 4'hf : 4'h0;
            #1;
            chk("rr_gnt", gnt_r, (c < 6) ? 33'(4'b1 << (c % 4)) : 33'd0);
            if (c >= 2) begin
                chk("rr_rsp", mr.rsp[(c - 2) % 4], rd(8'(16 + (c - 2) % 4)));
                chk("rr_other", mr.rsp[(c - 1) % 4], '0);
            end
        end
        // stall: man1 owns the bus while man0 arrives
        setr(1, 1'b0, 32'h80, '0);
        setr(0, 1'b0, 32'h84, '0);
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            mr.vld = {2'b00, s <= 3, s >= 1 && s <= 4};
            rdy_r = (s >= 3);
            #1;
            if (s <= 3) begin
                chk("hold_gnt", gnt_r, 4'b0010);
                chk("hold_rdy0", mr.rdy[0], 1'b0);
            end
            if (s == 3) chk("hold_rdy1", mr.rdy[1], 1'b1);
            if (s == 4) chk("after_hold_gnt", gnt_r, 4'b0001);
            if (s == 5) begin
                chk("hold_rsp1", mr.rsp[1], rd(8'h20));
                chk("hold_rsp0_idle", mr.rsp[0], '0);
            end
            if (s == 6) begin
                chk("hold_rsp0", mr.rsp[0], rd(8'h21));
                chk("hold_rsp1_idle", mr.rsp[1], '0);
            end
        end
        // write by man0 then read of the same word by man1
        setr(0, 1'b1, 32'h10, 32'h11223344);
        setr(1, 1'b0, 32'h10, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mr.vld = {2'b00, k == 1, k == 0};
            #1;
            if (k == 0) chk("il_gnt0", gnt_r, 4'b0001);
            if (k == 1) chk("il_gnt1", gnt_r, 4'b0010);
            if (k == 2) chk("il_rsp1_early", mr.rsp[1], '0);
            if (k == 3) begin
                chk("il_rsp1", mr.rsp[1], {32'h11223344, 1'b0});
                chk("il_rsp0", mr.rsp[0], '0);
            end
        end
        // single requester: back-to-back transfers without bubbles
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mr.vld = (k < 4) ? 4'b0010 : 4'b0000;
            setr(1, 1'b0, 32'h100 + 4 * k, '0);
            #1;
            if (k < 4) begin
                chk("single_gnt", gnt_r, 4'b0010);
                chk("single_rdy", mr.rdy[1], 1'b1);
            end
            if (k >= 2) chk("single_rsp", mr.rsp[1], rd(8'(64 + k - 2)));
        end
        // reset pulse between edges while a read is in flight
        setr(2, 1'b0, 32'h20, '0);
        @(negedge clk);
        mr.vld = 4'b0100;
        #1;
        chk("rp_gnt", gnt_r, 4'b0100);
        @(negedge clk);
        mr.vld = '0;
        rst = 1'b0;
        #1;
        chk("rp_async_gnt", gnt_r, '0);
        chk("rp_async_rsp", mr.rsp[2], '0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        mr.vld = 4'hf;
        #1;
        chk("rp_stale", mr.rsp[2], '0);
        chk("rp_ptr", gnt_r, 4'b0001);
        @(negedge clk);
        mr.vld = '0;
        // fixed priority: man0 starves man2
        mf.req[0] = {1'b0, 32'h30, 32'h0};
        mf.req[2] = {1'b0, 32'h34, 32'h0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mf.vld = (k < 4) ? 3'b101 : ((k == 4) ? 3'b100 : 3'b000);
            #1;
            if (k < 4) begin
                chk("fix_gnt", gnt_f, 3'b001);
                chk("fix_rdy2", mf.rdy[2], 1'b0);
            end
            if (k == 4) chk("fix_gnt2", gnt_f, 3'b100);
            if (k >= 1 && k <= 4) begin
                chk("fix_rsp0", mf.rsp[0], rd(8'h0c));
                chk("fix_rsp2_idle", mf.rsp[2], '0);
            end
            if (k == 5) chk("fix_rsp2", mf.rsp[2], rd(8'h0d));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
